dac_sample_feeder: RTL and testbench

Upstream stage for the 10-bit DAC model. Accepts DAC codes from the core over a valid/ready write port and buffers them in a small FIFO. Pops one code per programmable sample period and drives it onto the DAC digital input D[9:0], holding it between updates. Flags underflow when a sample event finds the FIFO empty.

---
 rtl/dac_feeder_pkg.sv | 8 +
 rtl/dac_sample_fifo.sv | 48 ++++
 rtl/dac_sample_feeder.sv | 73 +++++++
 tb/tb_dac_sample_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_feeder_pkg.sv
// Shared DAC code definitions for the sample feeder and its FIFO.
package dac_feeder_pkg;
  localparam int unsigned DAC_W          = 10;
  localparam int unsigned DAC_FULL_SCALE = 1023;
  localparam int unsigned DAC_MIDSCALE   = 512;

  typedef logic [DAC_W-1:0] dac_code_t;
endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO with a level counter; the head word is visible on rd_data.
module dac_sample_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full is judged on the pre-pop level, so a simultaneous pop never opens a slot.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end
endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers DAC codes from the core and releases one per programmable sample period.
module dac_sample_feeder
  import dac_feeder_pkg::*;
#(
  parameter int unsigned DATA_W = DAC_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [DIV_W-1:0]       div,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   clr_underflow,
  output logic [DATA_W-1:0]      dac_d,
  output logic                   sample_tick,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow
);
  logic [DIV_W-1:0]  cnt;
  logic              event_c;
  logic              push_c;
  logic              pop_ok_c;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  // >= lets a lowered div fire at once instead of wrapping the counter.
  assign event_c  = en && (cnt >= div);
  assign wr_ready = !reset && !full;
  assign push_c   = wr_valid && wr_ready;
  assign pop_ok_c = event_c && !empty;

  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .pop     (event_c),
    .wr_data (wr_data),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (reset || !en)  cnt <= '0;
    else if (event_c)  cnt <= '0;
    else               cnt <= cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dac_d       <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= pop_ok_c;
      if (pop_ok_c) dac_d <= head;
    end
  end

  // Setting beats clearing when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                  underflow <= 1'b0;
    else if (event_c && empty)  underflow <= 1'b1;
    else if (clr_underflow)     underflow <= 1'b0;
  end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder: cycle model plus directed checks.
module tb_dac_sample_feeder;
  import dac_feeder_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             wr_valid;
  dac_code_t        wr_data;
  logic             wr_ready;
  logic             clr_underflow;
  dac_code_t        dac_d;
  logic             sample_tick;
  logic [LVL_W-1:0] level;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cnt = 0;
  int max_lvl  = 0;

  // Reference model state
  dac_code_t exp_q[$];
  int        m_cnt  = 0;
  bit        m_uf   = 1'b0;
  dac_code_t m_dac  = '0;
  bit        m_tick = 1'b0;
  logic             s_reset, s_en, s_wv, s_cl;
  logic [DIV_W-1:0] s_div;
  dac_code_t        s_wd;
  bit               s_ev, s_push, s_had;

  always #5 clk = ~clk;

  dac_sample_feeder #(
    .DATA_W (DAC_W),
    .DEPTH  (DEPTH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .div           (div),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .clr_underflow (clr_underflow),
    .dac_d         (dac_d),
    .sample_tick   (sample_tick),
    .level         (level),
    .underflow     (underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model steps on the edge from pre-edge inputs, then compares just after it.
  always begin
    @(posedge clk);
    cyc++;
    s_reset = reset; s_en = en; s_div = div; s_wv = wr_valid; s_wd = wr_data; s_cl = clr_underflow;
    if (s_reset) begin
      exp_q.delete();
      m_cnt = 0; m_uf = 1'b0; m_dac = '0; m_tick = 1'b0;
    end else begin
      s_ev   = s_en && (m_cnt >= int'(s_div));
      s_push = s_wv && (exp_q.size() < DEPTH);
      s_had  = exp_q.size() > 0;
      m_tick = 1'b0;
      if (s_ev && s_had) begin
        m_dac  = exp_q.pop_front();
        m_tick = 1'b1;
      end
      if (s_ev && !s_had) m_uf = 1'b1;
      else if (s_cl)      m_uf = 1'b0;
      if (s_push) exp_q.push_back(s_wd);
      if (!s_en || s_ev) m_cnt = 0;
      else               m_cnt = m_cnt + 1;
    end
    #1;
    check_val("dac_d", 32'(dac_d), 32'(m_dac));
    check_val("sample_tick", 32'(sample_tick), 32'(m_tick));
    check_val("level", 32'(level), 32'(exp_q.size()));
    check_val("underflow", 32'(underflow), 32'(m_uf));
    check_val("wr_ready", 32'(wr_ready), 32'(!reset && (exp_q.size() < DEPTH)));
    if (sample_tick === 1'b1) tick_cnt++;
    if (int'(level) > max_lvl) max_lvl = int'(level);
  end

  task automatic write_word(input dac_code_t d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0;
  int pat [7] = '{1, 0, 0, 1, 0, 0, 1};

  initial begin
    reset = 1'b1; en = 1'b0; div = '0; wr_valid = 1'b0; wr_data = '0; clr_underflow = 1'b0;
    idle(3);
    check_val("rst_dac", 32'(dac_d), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    reset = 1'b0;
    idle(1);
    check_val("idle_ready", 32'(wr_ready), 32'd1);
    check_val("idle_uf", 32'(underflow), 32'd0);

    // Reset mid-stream with words queued
    for (int i = 0; i < 5; i++) write_word(dac_code_t'(100 + i));
    en = 1'b1; div = '0;
    idle(1);
    en = 1'b0;
    check_val("pre_rst_dac", 32'(dac_d), 32'd100);
    check_val("pre_rst_level", 32'(level), 32'd4);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_val("mid_rst_dac", 32'(dac_d), 32'd0);

    // Three codes at div=3
    en = 1'b1; div = DIV_W'(3);
    write_word(dac_code_t'(0));
    write_word(dac_code_t'(511));
    write_word(dac_code_t'(DAC_FULL_SCALE));
    t0 = tick_cnt;
    idle(14);
    check_val("t2_ticks", 32'(tick_cnt - t0), 32'd3);
    check_val("t2_dac", 32'(dac_d), 32'd1023);
    check_val("t2_uf", 32'(underflow), 32'd1);

    // Fill to full with the divider off, then drain at div=0
    en = 1'b0; clr_underflow = 1'b1;
    idle(1);
    clr_underflow = 1'b0;
    for (int i = 0; i < 9; i++) write_word(dac_code_t'(200 + i));
    check_val("t3_level", 32'(level), 32'd8);
    check_val("t3_ready", 32'(wr_ready), 32'd0);
    en = 1'b1; div = '0;
    t0 = tick_cnt;
    idle(8);
    en = 1'b0;
    check_val("t3_ticks", 32'(tick_cnt - t0), 32'd8);
    check_val("t3_dac", 32'(dac_d), 32'd207);
    check_val("t3_empty", 32'(level), 32'd0);

    // Streaming at div=0
    write_word(dac_code_t'(300));
    max_lvl = 0;
    en = 1'b1;
    for (int i = 1; i < 20; i++) write_word(dac_code_t'(300 + i));
    en = 1'b0;
    check_val("t4_maxlvl", 32'(max_lvl), 32'd1);
    check_val("t4_uf", 32'(underflow), 32'd0);
    check_val("t4_dac", 32'(dac_d), 32'd318);

    // div lowered from 9 to 2 while the counter sits at 5
    for (int i = 0; i < 6; i++) write_word(dac_code_t'(DAC_MIDSCALE + i));
    en = 1'b1; div = DIV_W'(9);
    idle(5);
    div = DIV_W'(2);
    for (int i = 0; i < 7; i++) begin
      idle(1);
      check_val("t5_tick", 32'(sample_tick), 32'(pat[i]));
    end
    en = 1'b0;

    // Set beats clear, then clear alone
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    en = 1'b1; div = '0; clr_underflow = 1'b1;
    idle(1);
    en = 1'b0;
    check_val("t6_set_wins", 32'(underflow), 32'd1);
    idle(1);
    clr_underflow = 1'b0;
    check_val("t6_cleared", 32'(underflow), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
